// File: rtl/ebreak_halt_ctrl.sv
// ebreak_halt_ctrl
// Watches the commit stream for EBREAK, freezes fetch, drains in-flight work
// for a fixed window and until writeback is idle, then latches a final halted
// state (verdict, exit code, trap PC, cycle and instruction counters) for the
// simulation harness to read.
module ebreak_halt_ctrl #(
  parameter int XLEN         = 64,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0,
  input  logic            wb_busy,
  output logic            fetch_stall,
  output logic            halted,
  output logic            good_trap,
  output logic [XLEN-1:0] exit_code,
  output logic [XLEN-1:0] trap_pc,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instr_cnt
);

  // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0.
  localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES);
  localparam logic [31:0]   EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_fetch_stall;
  logic            r_halted;
  logic            r_good_trap;
  logic [XLEN-1:0] r_exit_code;
  logic [XLEN-1:0] r_trap_pc;
  logic [63:0]     r_cycle_cnt;
  logic [63:0]     r_instr_cnt;

  state_t          w_state_next;
  logic [CW-1:0]   w_drain_cnt_next;
  logic            w_fetch_stall_next;
  logic            w_halted_next;
  logic            w_good_trap_next;
  logic [XLEN-1:0] w_exit_code_next;
  logic [XLEN-1:0] w_trap_pc_next;
  logic [63:0]     w_cycle_cnt_next;
  logic [63:0]     w_instr_cnt_next;
  logic            w_is_ebreak;

  // Only an exact EBREAK encoding that actually commits starts the halt sequence.
  assign w_is_ebreak = commit_valid && (commit_inst == EBREAK_INST);

  // Next-state and next-value logic; every register holds unless its state says otherwise.
  always_comb begin
    w_state_next       = r_state;
    w_drain_cnt_next   = r_drain_cnt;
    w_fetch_stall_next = r_fetch_stall;
    w_halted_next      = r_halted;
    w_good_trap_next   = r_good_trap;
    w_exit_code_next   = r_exit_code;
    w_trap_pc_next     = r_trap_pc;
    w_cycle_cnt_next   = r_cycle_cnt;
    w_instr_cnt_next   = r_instr_cnt;

    case (r_state)
      ST_RUN: begin
        w_cycle_cnt_next = r_cycle_cnt + 64'd1;
        if (commit_valid) begin
          w_instr_cnt_next = r_instr_cnt + 64'd1;
        end
        if (w_is_ebreak) begin
          w_exit_code_next   = a0;
          w_trap_pc_next     = commit_pc;
          w_drain_cnt_next   = DRAIN_LOAD;
          w_fetch_stall_next = 1'b1;
          w_state_next       = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_cycle_cnt_next = r_cycle_cnt + 64'd1;
        if (r_drain_cnt != '0) begin
          w_drain_cnt_next = r_drain_cnt - 1'b1;
        end
        if ((r_drain_cnt == '0) && !wb_busy) begin
          w_halted_next    = 1'b1;
          w_good_trap_next = (r_exit_code == '0);
          w_state_next     = ST_HALT;
        end
      end

      ST_HALT: begin
        w_state_next = ST_HALT;
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // State and output registers; reset clears every captured value immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_drain_cnt   <= '0;
      r_fetch_stall <= 1'b0;
      r_halted      <= 1'b0;
      r_good_trap   <= 1'b0;
      r_exit_code   <= '0;
      r_trap_pc     <= '0;
      r_cycle_cnt   <= '0;
      r_instr_cnt   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_drain_cnt   <= w_drain_cnt_next;
      r_fetch_stall <= w_fetch_stall_next;
      r_halted      <= w_halted_next;
      r_good_trap   <= w_good_trap_next;
      r_exit_code   <= w_exit_code_next;
      r_trap_pc     <= w_trap_pc_next;
      r_cycle_cnt   <= w_cycle_cnt_next;
      r_instr_cnt   <= w_instr_cnt_next;
    end
  end

  assign fetch_stall = r_fetch_stall;
  assign halted      = r_halted;
  assign good_trap   = r_good_trap;
  assign exit_code   = r_exit_code;
  assign trap_pc     = r_trap_pc;
  assign cycle_cnt   = r_cycle_cnt;
  assign instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
// Directed bench for ebreak_halt_ctrl: a default build (DRAIN_CYCLES=4) and a
// DRAIN_CYCLES=0 build share clock and reset.
module tb_ebreak_halt_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] ADDI   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        commitValid;
  logic [31:0] commitInst;
  logic [63:0] commitPc;
  logic [63:0] a0Val;
  logic        wbBusy;
  logic        fetchStall;
  logic        haltedOut;
  logic        goodTrap;
  logic [63:0] exitCode;
  logic [63:0] trapPc;
  logic [63:0] cycleCnt;
  logic [63:0] instrCnt;

  logic        zCommitValid;
  logic [31:0] zCommitInst;
  logic [63:0] zCommitPc;
  logic [63:0] zA0;
  logic        zWbBusy;
  logic        zFetchStall;
  logic        zHalted;
  logic        zGoodTrap;
  logic [63:0] zExitCode;
  logic [63:0] zTrapPc;
  logic [63:0] zCycleCnt;
  logic [63:0] zInstrCnt;

  int checkCount = 0;
  int failCount  = 0;

  ebreak_halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commitValid), .commit_inst(commitInst), .commit_pc(commitPc),
    .a0(a0Val), .wb_busy(wbBusy),
    .fetch_stall(fetchStall), .halted(haltedOut), .good_trap(goodTrap),
    .exit_code(exitCode), .trap_pc(trapPc),
    .cycle_cnt(cycleCnt), .instr_cnt(instrCnt)
  );

  ebreak_halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(0)) dutZero (
    .clk(clk), .rst(rst),
    .commit_valid(zCommitValid), .commit_inst(zCommitInst), .commit_pc(zCommitPc),
    .a0(zA0), .wb_busy(zWbBusy),
    .fetch_stall(zFetchStall), .halted(zHalted), .good_trap(zGoodTrap),
    .exit_code(zExitCode), .trap_pc(zTrapPc),
    .cycle_cnt(zCycleCnt), .instr_cnt(zInstrCnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] inst,
                               input logic [63:0] pc, input logic [63:0] a,
                               input logic busy);
    commitValid = v;
    commitInst  = inst;
    commitPc    = pc;
    a0Val       = a;
    wbBusy      = busy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_stall"},  {63'd0, fetchStall}, 64'd0);
    checkOutput({tag, "_halted"}, {63'd0, haltedOut},  64'd0);
    checkOutput({tag, "_good"},   {63'd0, goodTrap},   64'd0);
    checkOutput({tag, "_exit"},   exitCode, 64'd0);
    checkOutput({tag, "_pc"},     trapPc,   64'd0);
    checkOutput({tag, "_cyc"},    cycleCnt, 64'd0);
    checkOutput({tag, "_ins"},    instrCnt, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 64'd0, 64'd0, 1'b0);
    zCommitValid = 1'b0;
    zCommitInst  = 32'd0;
    zCommitPc    = 64'd0;
    zA0          = 64'd0;
    zWbBusy      = 1'b0;

    #2;
    checkCleared("reset");
    tick();

    // Release reset together with the first commit; five cycles, three commits.
    rst = 1'b0;
    applyStimulus(1'b1, ADDI, 64'h8000_0000, 64'd7, 1'b0); tick();
    applyStimulus(1'b0, ADDI, 64'h8000_0004, 64'd7, 1'b0); tick();
    applyStimulus(1'b1, ADDI, 64'h8000_0004, 64'd7, 1'b0); tick();
    applyStimulus(1'b1, ADDI, 64'h8000_0008, 64'd7, 1'b0); tick();
    applyStimulus(1'b0, ADDI, 64'h8000_000C, 64'd7, 1'b0); tick();
    checkOutput("run_instr", instrCnt, 64'd3);
    checkOutput("run_cycle", cycleCnt, 64'd5);
    checkOutput("run_stall", {63'd0, fetchStall}, 64'd0);
    checkOutput("run_halted", {63'd0, haltedOut}, 64'd0);

    // ECALL commits as an ordinary instruction; a non-committing EBREAK is ignored.
    applyStimulus(1'b1, ECALL,  64'h8000_000C, 64'h55, 1'b0); tick();
    applyStimulus(1'b0, EBREAK, 64'h8000_0010, 64'h66, 1'b0); tick();
    checkOutput("nomatch_stall", {63'd0, fetchStall}, 64'd0);
    checkOutput("nomatch_exit", exitCode, 64'd0);
    checkOutput("nomatch_pc", trapPc, 64'd0);
    checkOutput("nomatch_instr", instrCnt, 64'd4);
    checkOutput("nomatch_cycle", cycleCnt, 64'd7);

    // Good trap: EBREAK with a0=0, no writeback pending.
    applyStimulus(1'b1, EBREAK, 64'h8000_0010, 64'd0, 1'b0); tick();
    applyStimulus(1'b0, ADDI, 64'd0, 64'd0, 1'b0);
    checkOutput("good_stall_n1", {63'd0, fetchStall}, 64'd1);
    checkOutput("good_halted_n1", {63'd0, haltedOut}, 64'd0);
    checkOutput("good_pc", trapPc, 64'h8000_0010);
    checkOutput("good_exit", exitCode, 64'd0);
    checkOutput("good_instr", instrCnt, 64'd5);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("good_halted_n5", {63'd0, haltedOut}, 64'd0);
    tick();
    checkOutput("good_halted_n6", {63'd0, haltedOut}, 64'd1);
    checkOutput("good_trap_n6", {63'd0, goodTrap}, 64'd1);
    checkOutput("good_cycle", cycleCnt, 64'd13);
    tick(); tick();
    checkOutput("halt_cycle_frozen", cycleCnt, 64'd13);
    checkOutput("halt_stall", {63'd0, fetchStall}, 64'd1);

    // Asynchronous reset while halted.
    #2 rst = 1'b1;
    #1 checkCleared("rst_halt");
    tick();
    rst = 1'b0;

    // Bad trap with writeback held busy; younger commits and a second EBREAK are ignored.
    applyStimulus(1'b1, EBREAK, 64'h8000_0100, 64'h2A, 1'b1); tick();
    checkOutput("bad_stall", {63'd0, fetchStall}, 64'd1);
    checkOutput("bad_exit", exitCode, 64'h2A);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) applyStimulus(1'b1, EBREAK, 64'h8000_0200, 64'd0, 1'b1);
      else        applyStimulus(1'b1, ADDI,   64'h8000_0104, 64'd0, 1'b1);
      tick();
    end
    checkOutput("bad_halted_busy", {63'd0, haltedOut}, 64'd0);
    checkOutput("bad_instr_frozen", instrCnt, 64'd1);
    checkOutput("bad_exit_kept", exitCode, 64'h2A);
    checkOutput("bad_pc_kept", trapPc, 64'h8000_0100);
    applyStimulus(1'b0, ADDI, 64'd0, 64'd0, 1'b0); tick();
    checkOutput("bad_halted", {63'd0, haltedOut}, 64'd1);
    checkOutput("bad_good", {63'd0, goodTrap}, 64'd0);
    checkOutput("bad_exit_final", exitCode, 64'h2A);
    checkOutput("bad_cycle", cycleCnt, 64'd12);

    // Reset again, then reset two cycles into DRAIN.
    #2 rst = 1'b1;
    #1 checkCleared("rst_halt2");
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, EBREAK, 64'h200, 64'd5, 1'b0); tick();
    applyStimulus(1'b0, ADDI, 64'd0, 64'd0, 1'b0);
    tick(); tick();
    checkOutput("predrain_exit", exitCode, 64'd5);
    #2 rst = 1'b1;
    #1 checkCleared("rst_drain");
    tick();
    rst = 1'b0;

    // A fresh EBREAK after reset halts normally.
    applyStimulus(1'b1, EBREAK, 64'h300, 64'd0, 1'b0); tick();
    applyStimulus(1'b0, ADDI, 64'd0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("again_halted", {63'd0, haltedOut}, 64'd1);
    checkOutput("again_good", {63'd0, goodTrap}, 64'd1);
    checkOutput("again_pc", trapPc, 64'h300);

    // Zero-window build: halted visible two cycles after the commit cycle.
    zCommitValid = 1'b1; zCommitInst = EBREAK; zCommitPc = 64'h400; zA0 = 64'd9;
    tick();
    zCommitValid = 1'b0;
    checkOutput("zero_stall", {63'd0, zFetchStall}, 64'd1);
    checkOutput("zero_halted_n1", {63'd0, zHalted}, 64'd0);
    tick();
    checkOutput("zero_halted_n2", {63'd0, zHalted}, 64'd1);
    checkOutput("zero_good", {63'd0, zGoodTrap}, 64'd0);
    checkOutput("zero_exit", zExitCode, 64'd9);
    checkOutput("zero_pc", zTrapPc, 64'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
